// File: rtl/pcie_dma_read_fifo.sv
// Host-to-FPGA DMA read engine: issues 128-byte reads and reorders completions into per-tag slots.
// Latency: output word registered from slot RAM; first word valid at most 2 cycles after a slot fills.
// Backpressure: data/data_valid hold while !data_ready; requests hold until read_request_ready.
module pcie_dma_read_fifo #(
  parameter int          TAG_BITS  = 2,
  parameter logic [12:0] BASE_ADDR = 13'd32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pio_write_valid,
  input  logic [12:0] pio_write_address,
  input  logic [63:0] pio_write_data,
  output logic        read_request_valid,
  output logic [63:0] read_request_address,
  output logic [7:0]  read_request_tag,
  input  logic        read_request_ready,
  input  logic        completion_valid,
  input  logic [7:0]  completion_tag,
  input  logic [3:0]  completion_index,
  input  logic [63:0] completion_data,
  output logic        data_valid,
  output logic [63:0] data,
  input  logic        data_ready,
  output logic        active,
  output logic [23:0] block_count,
  output logic        error
);

  localparam int SLOTS = 1 << TAG_BITS;
  localparam int RAM_WORDS = SLOTS * 16;
  localparam logic [TAG_BITS-1:0] PTR_ONE = 1;

  // Per-slot lifecycle encoding
  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

  // Architectural state
  logic [63:0]         next_address_q, next_address_d;
  logic [23:0]         remaining_q, remaining_d;
  logic                active_q, active_d;
  logic [23:0]         block_count_q, block_count_d;
  logic                error_q, error_d;
  logic [TAG_BITS-1:0] issue_ptr_q, issue_ptr_d;
  logic [TAG_BITS-1:0] drain_ptr_q, drain_ptr_d;
  logic [3:0]          fetch_idx_q, fetch_idx_d;
  logic                fetch_done_q, fetch_done_d;
  logic                data_valid_q, data_valid_d;
  logic [63:0]         data_q, data_d;
  logic [1:0]          slot_st_q [SLOTS];
  logic [1:0]          slot_st_d [SLOTS];
  logic [15:0]         mask_q [SLOTS];
  logic [15:0]         mask_d [SLOTS];
  logic [63:0]         mem_q [RAM_WORDS];

  // Decoded control strobes
  logic                pio_addr_wr, pio_start_wr, pio_abort_wr, start_go;
  logic                req_valid, req_fire;
  logic [TAG_BITS-1:0] cpl_slot;
  logic                cpl_in_range, cpl_ok, cpl_bad;
  logic [TAG_BITS-1:0] ld_ptr;
  logic                out_accept, last_accept, load_en;
  logic                all_free;
  logic [TAG_BITS+3:0] rd_addr, wr_addr;

  // Decode PIO writes, request handshake, completion legality and drain controls
  always_comb begin
    pio_addr_wr  = pio_write_valid && (pio_write_address == BASE_ADDR);
    pio_start_wr = pio_write_valid && (pio_write_address == BASE_ADDR + 13'd1);
    pio_abort_wr = pio_write_valid && (pio_write_address == BASE_ADDR + 13'd2);
    // A start landing mid-transfer would corrupt slot bookkeeping, so it is dropped
    start_go     = pio_start_wr && !active_q;

    req_valid    = (slot_st_q[issue_ptr_q] == ST_FREE) && (remaining_q != 24'd0);
    req_fire     = req_valid && read_request_ready;

    cpl_slot     = completion_tag[TAG_BITS-1:0];
    cpl_in_range = (completion_tag >> TAG_BITS) == 8'd0;
    cpl_ok       = completion_valid && cpl_in_range &&
                   (slot_st_q[cpl_slot] == ST_PEND) &&
                   !mask_q[cpl_slot][completion_index];
    cpl_bad      = completion_valid && !cpl_ok;

    // Once word 15 of a block is in the output register, the fetch side looks
    // ahead to the next slot so consecutive blocks stream without a bubble.
    ld_ptr       = fetch_done_q ? (drain_ptr_q + PTR_ONE) : drain_ptr_q;
    out_accept   = data_valid_q && data_ready;
    last_accept  = out_accept && fetch_done_q;
    load_en      = (!data_valid_q || data_ready) && (slot_st_q[ld_ptr] == ST_FILL);

    rd_addr      = {ld_ptr, fetch_idx_q};
    wr_addr      = {cpl_slot, completion_index};
  end

  // Detect that no slot holds an outstanding or undelivered block
  always_comb begin
    all_free = 1'b1;
    for (int s = 0; s < SLOTS; s++) begin
      if (slot_st_q[s] != ST_FREE) all_free = 1'b0;
    end
  end

  // Next-state for registers, counters and the output stage
  always_comb begin
    next_address_d = next_address_q;
    remaining_d    = remaining_q;
    active_d       = active_q;
    block_count_d  = block_count_q;
    error_d        = error_q;
    issue_ptr_d    = issue_ptr_q;
    drain_ptr_d    = drain_ptr_q;
    fetch_idx_d    = fetch_idx_q;
    fetch_done_d   = fetch_done_q;
    data_valid_d   = data_valid_q;
    data_d         = data_q;

    // A PIO address write overrides the post-request increment
    if (pio_addr_wr) next_address_d = {pio_write_data[63:7], 7'b0};
    else if (req_fire) next_address_d = next_address_q + 64'd128;

    // Abort beats a same-cycle request decrement so the count cannot underflow
    if (start_go) remaining_d = pio_write_data[23:0];
    else if (pio_abort_wr) remaining_d = 24'd0;
    else if (req_fire) remaining_d = remaining_q - 24'd1;

    if (start_go) active_d = (pio_write_data[23:0] != 24'd0);
    else if ((remaining_q == 24'd0) && all_free) active_d = 1'b0;

    if (start_go) block_count_d = 24'd0;
    else if (last_accept) block_count_d = block_count_q + 24'd1;

    // A bad completion in the same cycle as a start still leaves error set
    if (cpl_bad) error_d = 1'b1;
    else if (start_go) error_d = 1'b0;

    if (req_fire) issue_ptr_d = issue_ptr_q + PTR_ONE;
    if (last_accept) drain_ptr_d = drain_ptr_q + PTR_ONE;

    if (load_en) begin
      fetch_idx_d  = fetch_idx_q + 4'd1;
      fetch_done_d = (fetch_idx_q == 4'd15);
      data_valid_d = 1'b1;
      data_d       = mem_q[rd_addr];
    end else begin
      if (last_accept) fetch_done_d = 1'b0;
      if (out_accept) data_valid_d = 1'b0;
    end
  end

  // Slot lifecycle: FREE -> PENDING on request, -> FILLED on full mask, -> FREE after word 15 leaves
  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      slot_st_d[s] = slot_st_q[s];
      mask_d[s]    = mask_q[s];
      if (req_fire && (issue_ptr_q == TAG_BITS'(s))) slot_st_d[s] = ST_PEND;
      if (cpl_ok && (cpl_slot == TAG_BITS'(s))) begin
        mask_d[s] = mask_q[s] | (16'd1 << completion_index);
        if (&mask_d[s]) slot_st_d[s] = ST_FILL;
      end
      if (last_accept && (drain_ptr_q == TAG_BITS'(s))) begin
        slot_st_d[s] = ST_FREE;
        mask_d[s]    = 16'd0;
      end
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clock) begin
    if (reset) begin
      next_address_q <= 64'd0;
      remaining_q    <= 24'd0;
      active_q       <= 1'b0;
      block_count_q  <= 24'd0;
      error_q        <= 1'b0;
      issue_ptr_q    <= '0;
      drain_ptr_q    <= '0;
      fetch_idx_q    <= 4'd0;
      fetch_done_q   <= 1'b0;
      data_valid_q   <= 1'b0;
      data_q         <= 64'd0;
      for (int s = 0; s < SLOTS; s++) begin
        slot_st_q[s] <= ST_FREE;
        mask_q[s]    <= 16'd0;
      end
    end else begin
      next_address_q <= next_address_d;
      remaining_q    <= remaining_d;
      active_q       <= active_d;
      block_count_q  <= block_count_d;
      error_q        <= error_d;
      issue_ptr_q    <= issue_ptr_d;
      drain_ptr_q    <= drain_ptr_d;
      fetch_idx_q    <= fetch_idx_d;
      fetch_done_q   <= fetch_done_d;
      data_valid_q   <= data_valid_d;
      data_q         <= data_d;
      for (int s = 0; s < SLOTS; s++) begin
        slot_st_q[s] <= slot_st_d[s];
        mask_q[s]    <= mask_d[s];
      end
    end
  end

  // Slot RAM write port; contents need no reset since masks gate every read
  always_ff @(posedge clock) begin
    if (cpl_ok) mem_q[wr_addr] <= completion_data;
  end

  assign read_request_valid   = req_valid;
  assign read_request_address = next_address_q;
  assign read_request_tag     = {{(8-TAG_BITS){1'b0}}, issue_ptr_q};
  assign data_valid           = data_valid_q;
  assign data                 = data_q;
  assign active               = active_q;
  assign block_count          = block_count_q;
  assign error                = error_q;

endmodule

// File: tb/tb_pcie_dma_read_fifo.sv
// Directed bench for pcie_dma_read_fifo: request issue, reordering, stalls, errors, reset.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: bench drives data_ready and read_request_ready explicitly per step.
module tb_pcie_dma_read_fifo;

  logic        clock;
  logic        reset;
  logic        pio_write_valid;
  logic [12:0] pio_write_address;
  logic [63:0] pio_write_data;
  logic        read_request_valid;
  logic [63:0] read_request_address;
  logic [7:0]  read_request_tag;
  logic        read_request_ready;
  logic        completion_valid;
  logic [7:0]  completion_tag;
  logic [3:0]  completion_index;
  logic [63:0] completion_data;
  logic        data_valid;
  logic [63:0] data;
  logic        data_ready;
  logic        active;
  logic [23:0] block_count;
  logic        error;

  int checks = 0;
  int errors = 0;

  pcie_dma_read_fifo #(.TAG_BITS(2), .BASE_ADDR(13'd32)) dut (
    .clock(clock), .reset(reset),
    .pio_write_valid(pio_write_valid), .pio_write_address(pio_write_address),
    .pio_write_data(pio_write_data),
    .read_request_valid(read_request_valid), .read_request_address(read_request_address),
    .read_request_tag(read_request_tag), .read_request_ready(read_request_ready),
    .completion_valid(completion_valid), .completion_tag(completion_tag),
    .completion_index(completion_index), .completion_data(completion_data),
    .data_valid(data_valid), .data(data), .data_ready(data_ready),
    .active(active), .block_count(block_count), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pio(input logic [12:0] addr, input logic [63:0] wdata);
    pio_write_valid   = 1'b1;
    pio_write_address = addr;
    pio_write_data    = wdata;
    tick();
    pio_write_valid   = 1'b0;
  endtask

  // Wait (bounded) for a request, check it, then accept it for one cycle
  task automatic expect_req(input string tag, input logic [63:0] addr, input logic [7:0] rtag);
    int n = 0;
    while (!read_request_valid && n < 200) begin tick(); n++; end
    chk({tag, "_vld"}, 64'(read_request_valid), 64'd1);
    chk({tag, "_addr"}, read_request_address, addr);
    chk({tag, "_tag"}, 64'(read_request_tag), 64'(rtag));
    read_request_ready = 1'b1;
    tick();
    read_request_ready = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] tag, input logic [63:0] addr, input bit rev);
    for (int i = 0; i < 16; i++) begin
      int idx;
      idx = rev ? 15 - i : i;
      completion_valid = 1'b1;
      completion_tag   = tag;
      completion_index = 4'(idx);
      completion_data  = (addr >> 3) + 64'(idx);
      tick();
    end
    completion_valid = 1'b0;
  endtask

  // Drain words first..15 of the block at addr with data_ready held high
  task automatic drain_block(input string tag, input logic [63:0] addr, input int first);
    data_ready = 1'b1;
    for (int i = first; i < 16; i++) begin
      int n = 0;
      while (!data_valid && n < 200) begin tick(); n++; end
      chk({tag, "_vld"}, 64'(data_valid), 64'd1);
      chk({tag, "_dat"}, data, (addr >> 3) + 64'(i));
      tick();
    end
    data_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    pio_write_valid = 1'b0; pio_write_address = '0; pio_write_data = '0;
    read_request_ready = 1'b0;
    completion_valid = 1'b0; completion_tag = '0; completion_index = '0; completion_data = '0;
    data_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_req_vld", 64'(read_request_valid), 64'd0);
    chk("rst_req_addr", read_request_address, 64'd0);
    chk("rst_req_tag", 64'(read_request_tag), 64'd0);
    chk("rst_dvld", 64'(data_valid), 64'd0);
    chk("rst_data", data, 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_bcnt", 64'(block_count), 64'd0);
    chk("rst_err", 64'(error), 64'd0);

    // Basic 3-block transfer; the low 7 address bits are discarded
    pio(13'd32, 64'h1000_007F);
    pio(13'd33, 64'd3);
    chk("t1_active", 64'(active), 64'd1);
    expect_req("t1_r0", 64'h1000_0000, 8'd0);
    expect_req("t1_r1", 64'h1000_0080, 8'd1);
    expect_req("t1_r2", 64'h1000_0100, 8'd2);
    read_request_ready = 1'b1;
    tick();
    chk("t1_no_4th", 64'(read_request_valid), 64'd0);
    read_request_ready = 1'b0;
    send_block(8'd0, 64'h1000_0000, 1'b0);
    send_block(8'd1, 64'h1000_0080, 1'b0);
    send_block(8'd2, 64'h1000_0100, 1'b0);
    drain_block("t1_b0", 64'h1000_0000, 0);
    drain_block("t1_b1", 64'h1000_0080, 0);
    drain_block("t1_b2", 64'h1000_0100, 0);
    tick(); tick();
    chk("t1_bcnt", 64'(block_count), 64'd3);
    chk("t1_active_end", 64'(active), 64'd0);
    chk("t1_dvld_end", 64'(data_valid), 64'd0);

    // Fresh reset, then fill all 4 slots with no completions
    reset = 1'b1; tick(); reset = 1'b0; tick();
    pio(13'd32, 64'd0);
    pio(13'd33, 64'd6);
    expect_req("t2_r0", 64'h000, 8'd0);
    expect_req("t2_r1", 64'h080, 8'd1);
    expect_req("t2_r2", 64'h100, 8'd2);
    expect_req("t2_r3", 64'h180, 8'd3);
    read_request_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t2_full_no_req", 64'(read_request_valid), 64'd0);
      tick();
    end
    read_request_ready = 1'b0;
    send_block(8'd0, 64'h000, 1'b0);
    drain_block("t2_b0", 64'h000, 0);
    expect_req("t2_r4", 64'h200, 8'd0);

    // A later slot fills first (reversed indices); output waits for the earlier slot
    send_block(8'd2, 64'h100, 1'b1);
    tick(); tick();
    chk("t3_hold_order", 64'(data_valid), 64'd0);
    send_block(8'd1, 64'h080, 1'b1);
    drain_block("t3_b1", 64'h080, 0);
    drain_block("t3_b2", 64'h100, 0);
    expect_req("t3_r5", 64'h280, 8'd1);
    read_request_ready = 1'b1;
    tick();
    chk("t3_no_7th", 64'(read_request_valid), 64'd0);
    read_request_ready = 1'b0;

    // Output stall with data_ready 1-0-0-1
    send_block(8'd3, 64'h180, 1'b0);
    begin
      int n = 0;
      while (!data_valid && n < 200) begin tick(); n++; end
    end
    chk("t4_w0", data, 64'h30);
    data_ready = 1'b1; tick();
    chk("t4_w1", data, 64'h31);
    data_ready = 1'b0; tick();
    chk("t4_stall1_dat", data, 64'h31);
    chk("t4_stall1_vld", 64'(data_valid), 64'd1);
    tick();
    chk("t4_stall2_dat", data, 64'h31);
    data_ready = 1'b1; tick();
    chk("t4_w2", data, 64'h32);
    drain_block("t4_b3", 64'h180, 2);
    send_block(8'd0, 64'h200, 1'b0);
    send_block(8'd1, 64'h280, 1'b0);
    drain_block("t4_b4", 64'h200, 0);
    drain_block("t4_b5", 64'h280, 0);
    tick(); tick(); tick();
    chk("t4_bcnt", 64'(block_count), 64'd6);
    chk("t4_active_end", 64'(active), 64'd0);

    // Protocol errors: out-of-range tag, then duplicate index; start clears error
    chk("t5_err_before", 64'(error), 64'd0);
    completion_valid = 1'b1; completion_tag = 8'd7; completion_index = 4'd0;
    completion_data = 64'hBAD0;
    tick();
    completion_valid = 1'b0;
    chk("t5_err_tag7", 64'(error), 64'd1);
    pio(13'd33, 64'd1);
    chk("t5_err_cleared", 64'(error), 64'd0);
    chk("t5_bcnt_cleared", 64'(block_count), 64'd0);
    expect_req("t5_r0", 64'h300, 8'd2);
    for (int i = 0; i < 16; i++) begin
      completion_valid = 1'b1; completion_tag = 8'd2; completion_index = 4'(i);
      completion_data = (64'h300 >> 3) + 64'(i);
      tick();
      if (i == 3) begin
        completion_data = 64'hDEAD_BEEF;
        tick();
      end
    end
    completion_valid = 1'b0;
    chk("t5_err_dup", 64'(error), 64'd1);
    drain_block("t5_b", 64'h300, 0);
    tick(); tick();
    chk("t5_bcnt", 64'(block_count), 64'd1);

    // Reset mid-transfer, then a late completion
    pio(13'd32, 64'h4000);
    tick(); tick();
    pio(13'd33, 64'd2);
    chk("t6_err_cleared", 64'(error), 64'd0);
    chk("t6_active", 64'(active), 64'd1);
    expect_req("t6_r0", 64'h4000, 8'd3);
    chk("t6_second_pending", 64'(read_request_valid), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_req_vld", 64'(read_request_valid), 64'd0);
    chk("t6_req_addr", read_request_address, 64'd0);
    chk("t6_req_tag", 64'(read_request_tag), 64'd0);
    chk("t6_dvld", 64'(data_valid), 64'd0);
    chk("t6_data", data, 64'd0);
    chk("t6_active_rst", 64'(active), 64'd0);
    chk("t6_bcnt", 64'(block_count), 64'd0);
    chk("t6_err_rst", 64'(error), 64'd0);
    completion_valid = 1'b1; completion_tag = 8'd0; completion_index = 4'd0;
    completion_data = 64'h800;
    tick();
    completion_valid = 1'b0;
    chk("t6_late_err", 64'(error), 64'd1);
    tick();
    chk("t6_late_no_out", 64'(data_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
